pc_run_monitor: RTL



---
 rtl/pc_run_monitor_pkg.sv | 33 +++
 rtl/sat_counter.sv | 35 +++
 rtl/pc_run_monitor.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pc_run_monitor_pkg.sv
// Shared types and helpers for the processor run monitor.
package pc_run_monitor_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2,
        HALTED  = 2'd3
    } mon_state_t;

    typedef enum logic [1:0] {
        SEL_PC      = 2'd0,
        SEL_RETIRED = 2'd1,
        SEL_CYCLES  = 2'd2,
        SEL_STATUS  = 2'd3
    } disp_sel_t;

    // Padding between the state nibble and the stall count in the status word.
    localparam logic [11:0] STATUS_ZERO = 12'h000;

    function automatic logic [DATA_W-1:0] status_word(input mon_state_t st,
                                                       input logic [STALL_CNT_W-1:0] stalls);
        return {2'b00, st, STATUS_ZERO, stalls};
    endfunction

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] x);
        return (x == {DATA_W{1'b1}}) ? x : x + DATA_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_run_monitor.sv
// Watches the processor retire stream, detects the halt PC, keeps run statistics
// and drives a refresh-throttled value to the seven-segment controller.
module pc_run_monitor
    import pc_run_monitor_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 1_000_000,
    parameter int unsigned STALL_CYCLES   = 4096
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic              instruction_done_in,
    input  logic [DATA_W-1:0] ending_pc_in,
    input  logic [1:0]        sel_in,
    output logic [DATA_W-1:0] val_out,
    output logic              halted_out,
    output logic              stalled_out,
    output logic [DATA_W-1:0] retired_out,
    output logic [DATA_W-1:0] cycles_out
);

    localparam int unsigned REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int unsigned GAP_W = $clog2(STALL_CYCLES);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STALL_CYCLES - 1);

    mon_state_t              state_q, state_d;
    logic [DATA_W-1:0]       last_pc_q, last_pc_d;
    logic [REF_W-1:0]        refresh_q, refresh_d;
    logic [DATA_W-1:0]       val_q, val_d;
    logic                    halted_q, halted_d;
    logic                    stalled_q, stalled_d;

    logic                    active;
    logic                    retire;
    logic                    halt_hit;
    logic                    gap_hit;
    logic                    halt_entry;
    logic                    stall_entry;
    logic                    tick;
    logic [GAP_W-1:0]        gap_cnt;
    logic [STALL_CNT_W-1:0]  stall_cnt;

    mon_state_t              src_state;
    logic [DATA_W-1:0]       src_pc;
    logic [DATA_W-1:0]       src_retired;
    logic [DATA_W-1:0]       src_cycles;

    assign active   = (state_q != HALTED);
    assign retire   = instruction_done_in && active;
    assign halt_hit = retire && (pc_in == ending_pc_in);
    assign gap_hit  = !instruction_done_in && (gap_cnt == GAP_LAST);
    assign tick     = (refresh_q == REF_LAST);

    sat_counter #(.WIDTH(DATA_W)) u_cycles (
        .clk(clk_in), .rst_n(rst_n_in), .clr(1'b0), .inc(active), .count(cycles_out)
    );

    sat_counter #(.WIDTH(DATA_W)) u_retired (
        .clk(clk_in), .rst_n(rst_n_in), .clr(1'b0), .inc(retire), .count(retired_out)
    );

    sat_counter #(.WIDTH(GAP_W), .MAX(GAP_LAST)) u_gap (
        .clk(clk_in), .rst_n(rst_n_in), .clr(retire), .inc(active), .count(gap_cnt)
    );

    sat_counter #(.WIDTH(STALL_CNT_W)) u_stalls (
        .clk(clk_in), .rst_n(rst_n_in), .clr(1'b0), .inc(stall_entry), .count(stall_cnt)
    );

    // Run-state FSM; a retire always takes priority over the gap limit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (halt_hit) begin
                    state_d = HALTED;
                end else if (retire) begin
                    state_d = RUN;
                end else if (gap_hit) begin
                    state_d = STALLED;
                end
            end
            RUN: begin
                if (halt_hit) begin
                    state_d = HALTED;
                end else if (gap_hit) begin
                    state_d = STALLED;
                end
            end
            STALLED: begin
                if (halt_hit) begin
                    state_d = HALTED;
                end else if (retire) begin
                    state_d = RUN;
                end
            end
            HALTED: state_d = HALTED;
        endcase
    end

    assign halt_entry  = (state_d == HALTED) && (state_q != HALTED);
    assign stall_entry = (state_d == STALLED) && (state_q != STALLED);

    // Display sources: on halt entry show the values the counters take at this edge.
    always_comb begin
        src_state   = state_q;
        src_pc      = last_pc_q;
        src_retired = retired_out;
        src_cycles  = cycles_out;
        if (halt_entry) begin
            src_state   = HALTED;
            src_pc      = pc_in;
            src_retired = sat_inc(retired_out);
            src_cycles  = sat_inc(cycles_out);
        end
    end

    always_comb begin
        last_pc_d = retire ? pc_in : last_pc_q;
        halted_d  = (state_d == HALTED);
        stalled_d = (state_d == STALLED);
        refresh_d = (tick || halt_entry) ? '0 : refresh_q + REF_W'(1);
        val_d     = val_q;
        if (tick || halt_entry) begin
            unique case (disp_sel_t'(sel_in))
                SEL_PC:      val_d = src_pc;
                SEL_RETIRED: val_d = src_retired;
                SEL_CYCLES:  val_d = src_cycles;
                SEL_STATUS:  val_d = status_word(src_state, stall_cnt);
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            last_pc_q <= '0;
            refresh_q <= '0;
            val_q     <= '0;
            halted_q  <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_pc_q <= last_pc_d;
            refresh_q <= refresh_d;
            val_q     <= val_d;
            halted_q  <= halted_d;
            stalled_q <= stalled_d;
        end
    end

    assign val_out     = val_q;
    assign halted_out  = halted_q;
    assign stalled_out = stalled_q;

endmodule
